pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register: the generalised successor of the fixed per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload plus a valid bit through `DEPTH` register slices, all controlled by the core's shared `stall` vector. The bubble/advance/hold rule from the existing stage registers is kept. It adds a flush input, a per-slice valid bit, an optional payload-clear mode, an occupancy output and a saturating bubble counter. It is instantiated between any two adjacent pipeline stages, and `DEPTH > 1` is used for multi-cycle stages.

---
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register.
// Carries a payload and a valid bit through DEPTH slices. It advances,
// inserts a bubble or holds, depending on the upstream and downstream
// bits of the shared stall vector. It also supports flush, reports
// occupancy and keeps a saturating bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 1,
  parameter int STALL_W       = 6,
  parameter int STAGE         = 3,
  parameter int CLEAR_PAYLOAD = 1,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [2:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam bit CLR = (CLEAR_PAYLOAD != 0);

  // Slice state: index 0 is fed from the inputs, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [2:0]                   r_occ;
  logic [CNT_W-1:0]             r_bubble_cnt;

  logic [DEPTH-1:0]             w_valid_next;
  logic [DEPTH-1:0][DATA_W-1:0] w_data_next;
  logic [2:0]                   w_occ_next;
  logic                         w_advance;
  logic                         w_bubble;
  logic                         w_shift;
  logic                         w_cnt_max;
  logic                         w_unused_stall;

  // The upstream stall bit alone decides advance. The illegal combination
  // (upstream running, downstream stalled) is deliberately treated as advance.
  assign w_advance = ~stall[STAGE];
  assign w_bubble  = stall[STAGE] & ~stall[STAGE+1];
  assign w_shift   = w_advance | w_bubble;
  assign w_cnt_max = &r_bubble_cnt;

  // Only two bits of the shared stall vector matter to this boundary.
  assign w_unused_stall = ^stall;

  // Next-state for every slice: flush beats shift, and shift beats hold.
  always_comb begin
    w_valid_next = r_valid;
    w_data_next  = r_data;
    if (flush) begin
      w_valid_next = '0;
      if (CLR) begin
        w_data_next = '0;
      end
    end else if (w_shift) begin
      // Every slice after the first takes its predecessor. The last entry
      // is simply overwritten because downstream captured it this cycle.
      for (int i = DEPTH - 1; i >= 1; i--) begin
        w_valid_next[i] = r_valid[i-1];
        w_data_next[i]  = r_data[i-1];
      end
      if (w_advance) begin
        w_valid_next[0] = in_valid;
        w_data_next[0]  = in_data;
      end else begin
        w_valid_next[0] = 1'b0;
        if (CLR) begin
          w_data_next[0] = '0;
        end
      end
    end
  end

  // Occupancy is counted from next-state valids so that it tracks the slices in the same cycle.
  always_comb begin
    w_occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_next = w_occ_next + {2'b00, w_valid_next[i]};
    end
  end

  // Slice and occupancy registers. Reset always zeroes the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_data  <= w_data_next;
      r_occ   <= w_occ_next;
    end
  end

  // Bubble counter: counts genuine bubble cycles only and saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!flush && w_bubble && !w_cnt_max) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_valid[DEPTH-1];
  assign out_data   = r_data[DEPTH-1];
  assign occupancy  = r_occ;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg.
// Four instances share one stimulus stream:
//   d1  : DEPTH=1, payload cleared
//   d2  : DEPTH=2, payload cleared
//   nc  : DEPTH=1, payload kept on bubble and flush
//   sat : DEPTH=1, 4-bit bubble counter
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;

  logic        d1_ov, d2_ov, nc_ov, sat_ov;
  logic [31:0] d1_od, d2_od, nc_od, sat_od;
  logic [2:0]  d1_occ, d2_occ, nc_occ, sat_occ;
  logic [15:0] d1_bc, d2_bc, nc_bc;
  logic [3:0]  sat_bc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .DEPTH(1), .STALL_W(6), .STAGE(3), .CLEAR_PAYLOAD(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(d1_ov), .out_data(d1_od), .occupancy(d1_occ), .bubble_cnt(d1_bc));

  pipe_stage_reg #(.DATA_W(32), .DEPTH(2), .STALL_W(6), .STAGE(3), .CLEAR_PAYLOAD(1), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(d2_ov), .out_data(d2_od), .occupancy(d2_occ), .bubble_cnt(d2_bc));

  pipe_stage_reg #(.DATA_W(32), .DEPTH(1), .STALL_W(6), .STAGE(3), .CLEAR_PAYLOAD(0), .CNT_W(16)) u_nc (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(nc_ov), .out_data(nc_od), .occupancy(nc_occ), .bubble_cnt(nc_bc));

  pipe_stage_reg #(.DATA_W(32), .DEPTH(1), .STALL_W(6), .STAGE(3), .CLEAR_PAYLOAD(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(sat_ov), .out_data(sat_od), .occupancy(sat_occ), .bubble_cnt(sat_bc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] s, input logic f,
                       input logic v, input logic [31:0] d);
    rst = r; stall = s; flush = f; in_valid = v; in_data = d;
  endtask

  // Advance one clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 6'b000000, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    step();
    // Reset state
    chk("rst d1 ov",  {31'b0, d1_ov}, 32'h0);
    chk("rst d1 od",  d1_od, 32'h0);
    chk("rst d1 occ", {29'b0, d1_occ}, 32'h0);
    chk("rst d1 bc",  {16'b0, d1_bc}, 32'h0);
    chk("rst d2 ov",  {31'b0, d2_ov}, 32'h0);
    chk("rst d2 occ", {29'b0, d2_occ}, 32'h0);
    chk("rst nc od",  nc_od, 32'h0);
    chk("rst sat bc", {28'b0, sat_bc}, 32'h0);

    // Streaming with no stalls
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'h11); step();
    chk("s1 d1 od",  d1_od, 32'h11);
    chk("s1 d1 ov",  {31'b0, d1_ov}, 32'h1);
    chk("s1 d2 ov",  {31'b0, d2_ov}, 32'h0);
    chk("s1 d2 occ", {29'b0, d2_occ}, 32'h1);
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'h22); step();
    chk("s2 d2 od",  d2_od, 32'h11);
    chk("s2 d2 ov",  {31'b0, d2_ov}, 32'h1);
    chk("s2 d2 occ", {29'b0, d2_occ}, 32'h2);
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'h33); step();
    chk("s3 d2 od",  d2_od, 32'h22);
    chk("s3 d1 od",  d1_od, 32'h33);
    // Invalid entry still carries its payload
    drive(1'b0, 6'b000000, 1'b0, 1'b0, 32'h44); step();
    chk("s4 d2 od",  d2_od, 32'h33);
    chk("s4 d2 occ", {29'b0, d2_occ}, 32'h1);
    chk("s4 d1 ov",  {31'b0, d1_ov}, 32'h0);
    chk("s4 d1 od",  d1_od, 32'h44);
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'h55); step();
    chk("s5 d1 od",  d1_od, 32'h55);
    chk("s5 d2 ov",  {31'b0, d2_ov}, 32'h0);
    chk("s5 d2 od",  d2_od, 32'h44);

    // Bubble for two cycles
    drive(1'b0, 6'b001000, 1'b0, 1'b1, 32'h99); step();
    chk("b1 d1 ov",  {31'b0, d1_ov}, 32'h0);
    chk("b1 d1 od",  d1_od, 32'h0);
    chk("b1 d1 bc",  {16'b0, d1_bc}, 32'h1);
    chk("b1 nc ov",  {31'b0, nc_ov}, 32'h0);
    chk("b1 nc od",  nc_od, 32'h55);
    chk("b1 d2 od",  d2_od, 32'h55);
    chk("b1 d2 ov",  {31'b0, d2_ov}, 32'h1);
    chk("b1 d2 occ", {29'b0, d2_occ}, 32'h1);
    step();
    chk("b2 d1 bc",  {16'b0, d1_bc}, 32'h2);
    chk("b2 d1 od",  d1_od, 32'h0);
    chk("b2 nc od",  nc_od, 32'h55);
    chk("b2 d2 ov",  {31'b0, d2_ov}, 32'h0);
    chk("b2 d2 occ", {29'b0, d2_occ}, 32'h0);

    // Hold after bubble: nothing moves, counter frozen
    drive(1'b0, 6'b011000, 1'b0, 1'b1, 32'h99);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("h1 d1 ov", {31'b0, d1_ov}, 32'h0);
      chk("h1 d1 bc", {16'b0, d1_bc}, 32'h2);
      chk("h1 nc od", nc_od, 32'h55);
    end

    // Refill, then hold with valid contents
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'hA1); step();
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'hA2); step();
    chk("r2 d2 od",  d2_od, 32'hA1);
    chk("r2 d2 occ", {29'b0, d2_occ}, 32'h2);
    drive(1'b0, 6'b011000, 1'b0, 1'b1, 32'hFF);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("h2 d2 od",  d2_od, 32'hA1);
      chk("h2 d2 occ", {29'b0, d2_occ}, 32'h2);
      chk("h2 d1 od",  d1_od, 32'hA2);
      chk("h2 d1 bc",  {16'b0, d1_bc}, 32'h2);
    end

    // Upstream running with downstream stalled: treated as advance
    drive(1'b0, 6'b010000, 1'b0, 1'b1, 32'hB3); step();
    chk("il d1 od",  d1_od, 32'hB3);
    chk("il d2 od",  d2_od, 32'hA2);
    chk("il d2 occ", {29'b0, d2_occ}, 32'h2);
    chk("il d1 bc",  {16'b0, d1_bc}, 32'h2);

    // Flush beats a simultaneous advance
    drive(1'b0, 6'b000000, 1'b1, 1'b1, 32'hC4); step();
    chk("f1 d2 occ", {29'b0, d2_occ}, 32'h0);
    chk("f1 d2 ov",  {31'b0, d2_ov}, 32'h0);
    chk("f1 d2 od",  d2_od, 32'h0);
    chk("f1 nc ov",  {31'b0, nc_ov}, 32'h0);
    chk("f1 nc od",  nc_od, 32'hB3);
    drive(1'b0, 6'b000000, 1'b0, 1'b1, 32'hD5); step();
    chk("f2 d2 ov",  {31'b0, d2_ov}, 32'h0);
    chk("f2 d2 od",  d2_od, 32'h0);
    chk("f2 d2 occ", {29'b0, d2_occ}, 32'h1);
    chk("f2 d1 od",  d1_od, 32'hD5);
    // Flush during bubble: no count
    drive(1'b0, 6'b001000, 1'b1, 1'b1, 32'hE6); step();
    chk("f3 d1 bc",  {16'b0, d1_bc}, 32'h2);
    chk("f3 nc od",  nc_od, 32'hD5);
    chk("f3 d2 occ", {29'b0, d2_occ}, 32'h0);

    // Mid-run reset during a bubble request
    drive(1'b1, 6'b001000, 1'b0, 1'b1, 32'h77); step();
    chk("r d1 bc",  {16'b0, d1_bc}, 32'h0);
    chk("r nc od",  nc_od, 32'h0);
    chk("r nc ov",  {31'b0, nc_ov}, 32'h0);

    // Saturation of a 4-bit counter over 20 bubbles
    drive(1'b0, 6'b001000, 1'b0, 1'b1, 32'h77);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("sat%0d", k), {28'b0, sat_bc}, (k > 15) ? 32'd15 : k);
    end
    chk("sat d1 bc", {16'b0, d1_bc}, 32'd20);
    chk("sat d1 ov", {31'b0, d1_ov}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
